photonic_tx_serializer: RTL

Data-plane transmit stage that sits directly downstream of a node's computer: it samples the 32-bit `data_tx_packet` word, queues complete packets in a small FIFO, and serialises each packet MSB-first onto a narrower photonic link lane under a valid/ready handshake. It decouples the processor's transmit timing from link availability. It also reports overflow when the link back-pressures longer than the queue can absorb.

---
 rtl/photonic_tx_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/photonic_tx_serializer.sv
// photonic_tx_serializer
// Captures 32-bit packets on a rising edge of tx_packet[31] and queues them in
// a DEPTH-entry FIFO. Each queued packet is sent MSB-first as 32/LANE_W beats
// on a valid/ready lane. Overflowing captures are dropped and counted.
// Optional feature macro: TX_PARITY_EN (adds the registered link_parity output).
module photonic_tx_serializer #(
    parameter int DEPTH  = 4,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       tx_packet,
    input  logic              link_ready,
    output logic              link_valid,
    output logic [LANE_W-1:0] link_data,
    output logic              link_sof,
    output logic              link_eof,
    output logic              fifo_full,
`ifdef TX_PARITY_EN
    output logic              link_parity,
`endif
    output logic [7:0]        drop_count
);

    localparam int BEATS = 32 / LANE_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = PW + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   rd_next;
    logic [OW-1:0]   occ_q, occ_d;
    logic            full_q, full_d;
    logic            prev31_q;
    logic [31:0]     shift_q, shift_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic [7:0]      drop_q, drop_d;
`ifdef TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic capture, handshake, last_beat, pop, push, drop;

    // Handshake, capture and FIFO bookkeeping decode.
    always_comb begin
        capture   = tx_packet[31] & ~prev31_q;
        handshake = (state_q == SEND) & link_ready;
        last_beat = (beat_q == LAST_BEAT);
        pop       = handshake & last_beat;
        // A full FIFO still accepts a capture in the cycle its head completes.
        push      = capture & (~full_q | pop);
        drop      = capture & full_q & ~pop;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        rd_next   = rd_ptr_q + PW'(1);
        occ_d     = occ_q + OW'(push) - OW'(pop);
        full_d    = (occ_d == OW'(DEPTH));
        drop_d    = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // Next-state, shift register and beat counter; flags are derived from the
    // next state so that every output leaves a flop.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    shift_d = mem_q[rd_ptr_q];
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!last_beat) begin
                        shift_d = shift_q << LANE_W;
                        beat_d  = beat_q + CW'(1);
                    end else if (occ_q > OW'(1)) begin
                        shift_d = mem_q[rd_next];
                        beat_d  = '0;
                    end else begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sof_d = (state_d == SEND) && (beat_d == '0);
        eof_d = (state_d == SEND) && (beat_d == LAST_BEAT);
    end

`ifdef TX_PARITY_EN
    // Even parity of the beat that will be presented next cycle.
    always_comb begin
        parity_d = ^shift_d[31:32-LANE_W];
    end
`endif

    // FIFO storage; no reset needed, occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_packet;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            prev31_q <= 1'b0;
            shift_q  <= '0;
            beat_q   <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            drop_q   <= '0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            prev31_q <= tx_packet[31];
            shift_q  <= shift_d;
            beat_q   <= beat_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            drop_q   <= drop_d;
`ifdef TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Output mapping from registers.
    always_comb begin
        link_valid  = (state_q == SEND);
        link_data   = shift_q[31:32-LANE_W];
        link_sof    = sof_q;
        link_eof    = eof_q;
        fifo_full   = full_q;
        drop_count  = drop_q;
`ifdef TX_PARITY_EN
        link_parity = parity_q;
`endif
    end

endmodule
